// File: rtl/iob_ram_sp_burst_rd_pkg.sv
// Shared definitions for the single-port RAM burst reader: FSM states,
// FIFO depth and the read-issue credit rule.
package iob_ram_sp_burst_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int FIFO_DEPTH = 2;

    // A read may issue while buffered words plus the outstanding read, minus this cycle's pop, stay below 2
    function automatic logic issue_credit(input logic [1:0] occ,
                                          input logic       inflight,
                                          input logic       pop);
        logic [2:0] held;
        held = {1'b0, occ} + {2'b00, inflight};
        return (held < (3'd2 + {2'b00, pop}));
    endfunction

endpackage

// File: rtl/iob_ram_sp_burst_rd_if.sv
// Valid/ready output stream of the burst reader.
interface iob_ram_sp_burst_rd_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/iob_ram_sp_rd_fifo2.sv
// Two-entry first-word-fall-through FIFO holding RAM read data until the
// stream consumer accepts it.
module iob_ram_sp_rd_fifo2
    import iob_ram_sp_burst_rd_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        occ_q, occ_d;
    logic              do_push, do_pop;

    assign empty = (occ_q == 2'd0);
    assign full  = (occ_q == 2'(FIFO_DEPTH));
    assign occ   = occ_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // FIFO state registers; reset flushes contents so the output reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: rtl/iob_ram_sp_burst_rd.sv
// Burst read initiator: reads len consecutive words from a single-port RAM
// with 1-cycle read latency and streams them out under backpressure.
module iob_ram_sp_burst_rd
    import iob_ram_sp_burst_rd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [LEN_W-1:0]      len,
    output logic                  busy,
    output logic                  done,
    iob_ram_sp_burst_rd_if.master m_if,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_din,
    input  logic [DATA_W-1:0]     ram_dout
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              inflight_q, inflight_d;
    logic              done_q, done_d;

    logic              fifo_empty, fifo_full;
    logic [1:0]        fifo_occ;
    logic [DATA_W-1:0] fifo_dout;
    logic              valid_s, pop_s, issue_s;

    assign valid_s = ~fifo_empty;
    assign pop_s   = valid_s & m_if.m_ready;

    // With the FIFO full nothing can be in flight, so only a pop frees a slot
    assign issue_s = (state_q == ST_RUN) &
                     (fifo_full ? pop_s : issue_credit(fifo_occ, inflight_q, pop_s));

    assign m_if.m_valid = valid_s;
    assign m_if.m_data  = fifo_dout;
    assign ram_en   = issue_s;
    assign ram_we   = 1'b0;
    assign ram_din  = '0;
    assign ram_addr = addr_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

    iob_ram_sp_rd_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .din   (ram_dout),
        .pop   (pop_s),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .occ   (fifo_occ)
    );

    // Burst FSM, address/remaining counters and completion pulse
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        inflight_d = issue_s;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d = ST_RUN;
                        addr_d  = base_addr;
                        rem_d   = len;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Last word leaves when nothing is in flight and it is the only one buffered
                if (!inflight_q && (fifo_occ == 2'd1) && pop_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

endmodule
